// File: rtl/aes_state_serializer.sv
// Purpose : unload one parallel AES word (ELEMENTS bytes, element 0 first) onto a byte-wide valid/ready stream.
// Latency : word accepted at edge N presents byte 0 right after edge N; one byte per accepted beat after that.
// Backpr. : o/o_valid/o_last/counter hold while o_ready=0; a new word can load on the edge the last byte leaves.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   i_valid/i_ready/i    parallel word input handshake; i[0] is emitted first
//   flush                synchronous abort of the word in progress (buffer contents kept)
//   o_valid/o_ready/o    byte output handshake
//   o_last               marks element ELEMENTS-1
//   busy                 a word is held and being emitted
module aes_state_serializer #(
  parameter int ELEMENTS = 16,
  parameter int CW       = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [ELEMENTS-1:0][7:0] i,
  input  logic                     flush,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [7:0]               o,
  output logic                     o_last,
  output logic                     busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [CW-1:0] LAST_IDX = CW'(ELEMENTS - 1);

  logic [0:0]               state_q;
  logic [CW-1:0]            cnt_q;
  logic [ELEMENTS-1:0][7:0] hold_q;

  logic load;
  logic xfer;

  assign o_valid = (state_q == SHIFT);
  assign busy    = (state_q == SHIFT);
  assign o_last  = (state_q == SHIFT) && (cnt_q == LAST_IDX);
  assign o       = hold_q[cnt_q];

  // Accepting while the final byte leaves removes the bubble between words.
  assign i_ready = (state_q == IDLE) || ((state_q == SHIFT) && o_last && o_ready);

  // Flush wins over both handshakes even though i_ready may read high.
  assign load = i_valid && i_ready && !flush;
  assign xfer = o_valid && o_ready && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (load) begin
      // Covers both the IDLE load and the back-to-back load on the last byte.
      hold_q  <= i;
      cnt_q   <= '0;
      state_q <= SHIFT;
    end else if (xfer) begin
      if (o_last) begin
        cnt_q   <= '0;
        state_q <= IDLE;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_aes_state_serializer.sv
module tb_aes_state_serializer;

  localparam int E = 16;

  logic              clk = 1'b0;
  logic              resetn;
  logic              i_valid;
  logic              i_ready;
  logic [E-1:0][7:0] wd;
  logic              flush;
  logic              o_valid;
  logic              o_ready;
  logic [7:0]        o;
  logic              o_last;
  logic              busy;

  logic              i4_valid, i4_ready, o4_valid, o4_ready, o4_last, busy4, flush4;
  logic [3:0][7:0]   w4;
  logic [7:0]        o4;

  // Reference model: bytes of the current word still to be emitted, in order.
  logic [7:0] q[$];
  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  aes_state_serializer #(.ELEMENTS(16), .CW(4)) dut (
    .clk(clk), .resetn(resetn), .i_valid(i_valid), .i_ready(i_ready), .i(wd),
    .flush(flush), .o_valid(o_valid), .o_ready(o_ready), .o(o), .o_last(o_last), .busy(busy));

  aes_state_serializer #(.ELEMENTS(4), .CW(2)) dut4 (
    .clk(clk), .resetn(resetn), .i_valid(i4_valid), .i_ready(i4_ready), .i(w4),
    .flush(flush4), .o_valid(o4_valid), .o_ready(o4_ready), .o(o4), .o_last(o4_last), .busy(busy4));

  function automatic logic exp_ready();
    return (q.size() == 0) || (q.size() == 1 && o_ready);
  endfunction

  // Advance one clock and update the model from the spec's transfer rules.
  task automatic tick();
    logic acc, xf;
    @(posedge clk);
    acc = i_valid && exp_ready() && !flush && resetn;
    xf  = (q.size() != 0) && o_ready && !flush && resetn;
    if (flush) q.delete();
    else begin
      if (xf) void'(q.pop_front());
      if (acc) for (int k = 0; k < E; k++) q.push_back(wd[k]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; i_valid = 1'b0; flush = 1'b0; o_ready = 1'b0; wd = '0;
    i4_valid = 1'b0; o4_ready = 1'b0; flush4 = 1'b0; w4 = '0;
    q.delete();
    #1;
    ntests++; if (o_valid !== 1'b0) begin nfail++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
    ntests++; if (o_last !== 1'b0)  begin nfail++; $display("FAIL reset_o_last got %b want 0", o_last); end
    ntests++; if (busy !== 1'b0)    begin nfail++; $display("FAIL reset_busy got %b want 0", busy); end
    ntests++; if (o !== 8'h00)      begin nfail++; $display("FAIL reset_o got %h want 00", o); end
    ntests++; if (i_ready !== 1'b1) begin nfail++; $display("FAIL reset_i_ready got %b want 1", i_ready); end
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    for (int k = 0; k < E; k++) wd[k] = 8'(k);
    o_ready = 1'b1; i_valid = 1'b1; #1;
    ntests++; if (i_ready !== 1'b1) begin nfail++; $display("FAIL single_idle_ready got %b want 1", i_ready); end
    tick();
    i_valid = 1'b0;
    for (int c = 0; c < E; c++) begin
      #1;
      ntests++; if (o_valid !== 1'b1 || o !== 8'(c)) begin nfail++; $display("FAIL single_byte%0d got v=%b o=%h want v=1 o=%h", c, o_valid, o, 8'(c)); end
      ntests++; if (o_last !== (c == E-1) || busy !== 1'b1) begin nfail++; $display("FAIL single_last%0d got last=%b busy=%b", c, o_last, busy); end
      tick();
    end
    #1;
    ntests++; if (o_valid !== 1'b0 || busy !== 1'b0 || i_ready !== 1'b1) begin nfail++; $display("FAIL single_end got v=%b busy=%b rdy=%b want 0 0 1", o_valid, busy, i_ready); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int xfers = 0;
    int c = 0;
    logic [7:0] prev_o;
    logic prev_stall = 1'b0;
    for (int k = 0; k < E; k++) wd[k] = 8'($urandom);
    o_ready = 1'b1; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    while (q.size() != 0 && c < 100) begin
      o_ready = ((c % 3) == 0);
      #1;
      ntests++; if (o_valid !== 1'b1 || o !== q[0]) begin nfail++; $display("FAIL bp_byte c%0d got v=%b o=%h want v=1 o=%h", c, o_valid, o, q[0]); end
      ntests++; if (o_last !== (q.size() == 1)) begin nfail++; $display("FAIL bp_last c%0d got %b want %b", c, o_last, q.size() == 1); end
      if (prev_stall) begin
        ntests++; if (o !== prev_o) begin nfail++; $display("FAIL bp_stable c%0d got %h want %h", c, o, prev_o); end
      end
      prev_o = o; prev_stall = !o_ready;
      if (o_ready) xfers++;
      tick();
      c++;
    end
    #1;
    ntests++; if (xfers != E || o_valid !== 1'b0) begin nfail++; $display("FAIL bp_count got xfers=%0d v=%b want %0d v=0", xfers, o_valid, E); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic acc;
    int ready_pulses = 0;
    o_ready = 1'b1;
    wd = {E{8'hAA}}; i_valid = 1'b1;
    tick();
    wd = {E{8'h55}};
    for (int c = 0; c < 2*E; c++) begin
      #1;
      ntests++; if (o_valid !== 1'b1 || o !== ((c < E) ? 8'hAA : 8'h55)) begin nfail++; $display("FAIL b2b_byte%0d got v=%b o=%h", c, o_valid, o); end
      ntests++; if (i_ready !== exp_ready()) begin nfail++; $display("FAIL b2b_ready%0d got %b want %b", c, i_ready, exp_ready()); end
      if (i_ready === 1'b1 && i_valid) ready_pulses++;
      acc = i_valid && exp_ready();
      tick();
      if (acc) i_valid = 1'b0;
    end
    #1;
    ntests++; if (ready_pulses != 1 || o_valid !== 1'b0) begin nfail++; $display("FAIL b2b_end got pulses=%0d v=%b want 1 v=0", ready_pulses, o_valid); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    for (int k = 0; k < E; k++) wd[k] = 8'(k);
    o_ready = 1'b1; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (5) tick();
    #1;
    ntests++; if (o !== 8'h05) begin nfail++; $display("FAIL flush_pre got %h want 05", o); end
    flush = 1'b1; i_valid = 1'b1;
    for (int k = 0; k < E; k++) wd[k] = 8'hE0 + 8'(k);
    tick();
    flush = 1'b0; i_valid = 1'b0; #1;
    ntests++; if (o_valid !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL flush_idle got v=%b busy=%b want 0 0", o_valid, busy); end
    for (int k = 0; k < E; k++) wd[k] = 8'h10 + 8'(k);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int c = 0; c < E; c++) begin
      #1;
      ntests++; if (o_valid !== 1'b1 || o !== q[0] || o !== 8'h10 + 8'(c)) begin nfail++; $display("FAIL flush_reload%0d got v=%b o=%h want %h", c, o_valid, o, 8'h10 + 8'(c)); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < E; k++) wd[k] = 8'($urandom);
    o_ready = 1'b1; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (7) tick();
    #1;
    ntests++; if (o !== wd[7]) begin nfail++; $display("FAIL arst_pre got %h want %h", o, wd[7]); end
    #1 resetn = 1'b0;
    #1;
    ntests++; if (o_valid !== 1'b0 || busy !== 1'b0 || o_last !== 1'b0) begin nfail++; $display("FAIL arst_drop got v=%b busy=%b last=%b want 0", o_valid, busy, o_last); end
    q.delete();
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      ntests++; if (o_valid !== 1'b0 || o !== 8'h00) begin nfail++; $display("FAIL arst_after%0d got v=%b o=%h want 0 00", c, o_valid, o); end
      tick();
    end
  endtask

  task automatic test_elements4();
    logic [7:0] exp4 [4];
    exp4 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    w4 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    o4_ready = 1'b1; i4_valid = 1'b1;
    tick();
    i4_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      ntests++; if (o4_valid !== 1'b1 || o4 !== exp4[c] || o4_last !== (c == 3)) begin nfail++; $display("FAIL e4_byte%0d got v=%b o=%h last=%b want %h", c, o4_valid, o4, o4_last, exp4[c]); end
      tick();
    end
    #1;
    ntests++; if (o4_valid !== 1'b0 || i4_ready !== 1'b1) begin nfail++; $display("FAIL e4_end got v=%b rdy=%b want 0 1", o4_valid, i4_ready); end
    w4 = {8'h44, 8'h33, 8'h22, 8'h11}; i4_valid = 1'b1;
    tick();
    i4_valid = 1'b0; #1;
    ntests++; if (o4 !== 8'h11 || o4_valid !== 1'b1) begin nfail++; $display("FAIL e4_wrap got v=%b o=%h want 1 11", o4_valid, o4); end
    repeat (5) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < E; k++) wd[k] = 8'($urandom);
      i_valid = ($urandom_range(0, 1) == 1);
      o_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 31) == 0);
      #1;
      ntests++; if (o_valid !== (q.size() != 0) || busy !== (q.size() != 0)) begin nfail++; $display("FAIL rnd_valid c%0d got v=%b busy=%b want %b", c, o_valid, busy, q.size() != 0); end
      ntests++; if (i_ready !== exp_ready()) begin nfail++; $display("FAIL rnd_ready c%0d got %b want %b", c, i_ready, exp_ready()); end
      if (q.size() != 0) begin
        ntests++; if (o !== q[0] || o_last !== (q.size() == 1)) begin nfail++; $display("FAIL rnd_byte c%0d got o=%h last=%b want o=%h last=%b", c, o, o_last, q[0], q.size() == 1); end
      end
      tick();
    end
    i_valid = 1'b0; flush = 1'b0; o_ready = 1'b1;
    repeat (E + 1) tick();
    #1;
    ntests++; if (o_valid !== 1'b0 || q.size() != 0) begin nfail++; $display("FAIL rnd_drain got v=%b left=%0d want 0 0", o_valid, q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_elements4();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
